wb_mem_responder: RTL

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_mem_responder.sv
// Wishbone word-memory responder: 16-bit words, byte enables, optional 4/8-beat
// wrapping bursts, programmable initial wait and out-of-range error response.
module wb_mem_responder #(
    parameter int unsigned WB_ADDR_W  = 24,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT       = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [WB_ADDR_W-1:0] wb_adr,
    input  logic [15:0]          wb_i_dat,
    input  logic [1:0]           wb_sel,
    input  logic                 wb_8_burst,
    input  logic                 wb_4_burst,
    output logic [15:0]          wb_o_dat,
    output logic                 wb_ack,
    output logic                 wb_err,
    output logic                 wb_rty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StErr} state_e;

    state_e                  state_q;
    logic [DEPTH_LOG2-1:0]   adr_q;
    logic                    we_q;
    logic                    fail_q;
    logic [3:0]              len_q;
    logic [3:0]              wait_q;
    logic [2:0]              beat_q;

    logic [15:0]             mem [DEPTH];

    logic                    req_accept;
    logic [3:0]              req_len;
    logic                    req_fail;
    logic [DEPTH_LOG2-1:0]   blk_mask;
    logic [DEPTH_LOG2-1:0]   beat_idx;
    logic                    last_beat;
    logic                    wr_en;

    assign wb_rty = 1'b0;

    // Request decode and beat addressing; the beat offset wraps inside the aligned block.
    always_comb begin
        // Holding off while ack/err is still visible guarantees an idle cycle between transfers.
        req_accept = (state_q == StIdle) && wb_cyc && wb_stb && !wb_ack && !wb_err;
        req_len    = wb_8_burst ? 4'd8 : (wb_4_burst ? 4'd4 : 4'd1);
        req_fail   = ((wb_adr >> DEPTH_LOG2) != '0) || (32'(req_len) > DEPTH);
        blk_mask   = DEPTH_LOG2'(len_q - 4'd1);
        beat_idx   = (adr_q & ~blk_mask) | ((adr_q + DEPTH_LOG2'(beat_q)) & blk_mask);
        last_beat  = ({1'b0, beat_q} == (len_q - 4'd1));
        wr_en      = (state_q == StBurst) && wb_cyc && wb_stb && we_q;
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            if (wb_sel[0]) mem[beat_idx][7:0]  <= wb_i_dat[7:0];
            if (wb_sel[1]) mem[beat_idx][15:8] <= wb_i_dat[15:8];
        end
    end

    // Transaction FSM with registered ack/err/read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            we_q     <= 1'b0;
            fail_q   <= 1'b0;
            len_q    <= '0;
            wait_q   <= '0;
            beat_q   <= '0;
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_o_dat <= '0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_accept) begin
                        adr_q  <= wb_adr[DEPTH_LOG2-1:0];
                        we_q   <= wb_we;
                        len_q  <= req_len;
                        fail_q <= req_fail;
                        beat_q <= '0;
                        if (WAIT > 0) begin
                            state_q <= StWait;
                            wait_q  <= 4'(WAIT);
                        end else begin
                            state_q <= req_fail ? StErr : StBurst;
                        end
                    end
                end
                StWait: begin
                    if (!wb_cyc) begin
                        state_q <= StIdle;
                        wait_q  <= '0;
                    end else if (wait_q <= 4'd1) begin
                        // Counter reaches zero together with the move to the response state.
                        wait_q  <= '0;
                        state_q <= fail_q ? StErr : StBurst;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StBurst: begin
                    if (!wb_cyc) begin
                        state_q <= StIdle;
                        beat_q  <= '0;
                    end else if (wb_stb) begin
                        wb_ack <= 1'b1;
                        if (!we_q) wb_o_dat <= mem[beat_idx];
                        if (last_beat) begin
                            state_q <= StIdle;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 3'd1;
                        end
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                    if (wb_cyc) wb_err <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
